// File: rtl/smart_house_pkg.sv
// smart_house_pkg -- shared definitions for the smart-house serial blocks.
//   SH_WORD_W      : default data word width
//   rx_state_t     : serial receiver FSM state encoding, with named constants
//   even_parity_ok : even-parity check over a data word plus its parity bit
package smart_house_pkg;

  localparam int SH_WORD_W = 8;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t ST_IDLE   = 2'd0;
  localparam rx_state_t ST_DATA   = 2'd1;
  localparam rx_state_t ST_PARITY = 2'd2;
  localparam rx_state_t ST_STOP   = 2'd3;

  // The data is zero-extended to 16 bits by the caller; extra zeros do not change the XOR.
  function automatic logic even_parity_ok(input logic [15:0] data, input logic pbit);
    return ~(^{data, pbit});
  endfunction

endpackage

// File: rtl/dflop.sv
// DFlop -- single D flip-flop cell with enable and parallel-load select.
//   clk, arst_n : clock, asynchronous active-low reset (clears q)
//   en          : capture enable; q holds when low
//   eload       : 1 selects ld, 0 selects din
//   din, ld     : serial and parallel data inputs
//   q           : registered output
module DFlop (
  input  logic clk,
  input  logic arst_n,
  input  logic en,
  input  logic eload,
  input  logic din,
  input  logic ld,
  output logic q
);

  // Storage flop: capture din or ld when enabled.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q <= 1'b0;
    end else if (en) begin
      q <= eload ? ld : din;
    end
  end

endmodule

// File: rtl/sipo_shift.sv
// sipo_shift -- serial-in parallel-out shift register built from DFlop cells.
//   clk, arst_n : clock, asynchronous active-low reset (clears all bits)
//   shift_en    : shift one position toward the LSB, sin entering at the MSB
//   sin         : serial data input
//   q           : parallel contents; after WIDTH shifts the first bit is in q[0]
module sipo_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  // chain_s[WIDTH] is the serial input; chain_s[i] is the output of cell i.
  logic [WIDTH:0] chain_s;

  assign chain_s[WIDTH] = sin;
  assign q              = chain_s[WIDTH-1:0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    DFlop u_cell (
      .clk    (clk),
      .arst_n (arst_n),
      .en     (shift_en),
      .eload  (1'b0),
      .din    (chain_s[i+1]),
      .ld     (1'b0),
      .q      (chain_s[i])
    );
  end

endmodule

// File: rtl/serial_word_rx.sv
// serial_word_rx -- start/data/[parity]/stop serial word receiver with a
// one-word valid/ready output holding register.
//   clk, arst_n : clock, asynchronous active-low reset
//   bit_tick    : one-cycle strobe at each serial bit sample point
//   sin         : serial line (idle high, already synchronised)
//   dout/dvalid : received word and its valid flag; dready consumes it
//   busy        : FSM not in IDLE
//   frame_err   : one-cycle pulse, bad stop bit
//   parity_err  : one-cycle pulse, parity mismatch (0 without parity)
//   overrun     : one-cycle pulse, completed word dropped because dout was full
// Build option: define SERIAL_RX_PARITY_EN to add an even-parity bit after the data.
module serial_word_rx
  import smart_house_pkg::*;
#(
  parameter int WIDTH = SH_WORD_W
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             bit_tick,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  input  logic             dready,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam logic [4:0] LAST_CNT = 5'(WIDTH - 1);
`ifdef SERIAL_RX_PARITY_EN
  localparam rx_state_t ST_AFTER_DATA = ST_PARITY;
`else
  localparam rx_state_t ST_AFTER_DATA = ST_STOP;
`endif

  rx_state_t        state_r, next_state_s;
  logic [4:0]       cnt_r;
  logic [WIDTH-1:0] shift_q_s;
  logic             shift_en_s;
  logic             complete_s;
  logic             stop_bad_s;
  logic             parity_ok_s;
  logic [WIDTH-1:0] dout_r;
  logic             dvalid_r;
  logic             busy_r;
  logic             frame_err_r;
  logic             overrun_r;

  sipo_shift #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .arst_n   (arst_n),
    .shift_en (shift_en_s),
    .sin      (sin),
    .q        (shift_q_s)
  );

`ifdef SERIAL_RX_PARITY_EN
  logic par_bit_r;
  logic par_bad_s;
  logic parity_err_r;

  // The word is complete in the shift register by the time the parity bit is checked in STOP.
  assign parity_ok_s = even_parity_ok(16'(shift_q_s), par_bit_r);
`else
  assign parity_ok_s = 1'b1;
`endif

  // Next-state and per-tick event decode; nothing happens without bit_tick.
  always_comb begin
    next_state_s = state_r;
    shift_en_s   = 1'b0;
    complete_s   = 1'b0;
    stop_bad_s   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_bad_s    = 1'b0;
`endif
    if (bit_tick) begin
      case (state_r)
        ST_IDLE: begin
          if (!sin) begin
            next_state_s = ST_DATA;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_en_s = 1'b1;
          if (cnt_r == LAST_CNT) begin
            next_state_s = ST_AFTER_DATA;
          end else begin
            next_state_s = ST_DATA;
          end
        end
        ST_PARITY: begin
`ifdef SERIAL_RX_PARITY_EN
          next_state_s = ST_STOP;
`else
          next_state_s = ST_IDLE;
`endif
        end
        ST_STOP: begin
          next_state_s = ST_IDLE;
          stop_bad_s   = ~sin;
          complete_s   = sin & parity_ok_s;
`ifdef SERIAL_RX_PARITY_EN
          par_bad_s    = ~parity_ok_s;
`endif
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // FSM state, bit counter and busy flag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 5'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != ST_IDLE);
      if (bit_tick && (state_r == ST_IDLE) && !sin) begin
        cnt_r <= 5'd0;
      end else if (shift_en_s) begin
        cnt_r <= cnt_r + 5'd1;
      end
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  // Parity bit capture and parity error pulse.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      par_bit_r    <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      parity_err_r <= par_bad_s;
      if (bit_tick && (state_r == ST_PARITY)) begin
        par_bit_r <= sin;
      end
    end
  end

  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

  // Output holding register: a completion may load in the same cycle the old word is consumed.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      dout_r      <= '0;
      dvalid_r    <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= stop_bad_s;
      overrun_r   <= complete_s & dvalid_r & ~dready;
      if (complete_s && (!dvalid_r || dready)) begin
        dout_r   <= shift_q_s;
        dvalid_r <= 1'b1;
      end else if (dvalid_r && dready) begin
        dvalid_r <= 1'b0;
      end
    end
  end

  assign dout      = dout_r;
  assign dvalid    = dvalid_r;
  assign busy      = busy_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule
